instruction_encode: RTL and testbench

- Streaming RV32I instruction encoder. It is the inverse of the decode stage.
- It accepts decoded fields (opcode, funct3, funct7, rd, rs1, rs2, 32-bit immediate) over a valid/ready handshake and packs them into 32-bit instruction words.
- Each legal word is written sequentially into instruction memory through a registered write port, one word per 4-byte PC step from a programmable base.
- Used by the boot/self-test loader to build programs in the fetch stage's memory and by the verification bench as a reference assembler.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/instr_pack.sv | 53 +++++
 rtl/instruction_encode.sv | 133 +++++++++++++
 tb/tb_instruction_encode.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// RV32I encoding constants, instruction format classes and error codes, shared
// by the encoder and the decode stage.
package riscv_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } instr_fmt_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_OPCODE    = 3'd1,
    ERR_IMM_RANGE = 3'd2,
    ERR_MISALIGN  = 3'd3,
    ERR_U_LOW     = 3'd4,
    ERR_SHAMT     = 3'd5,
    ERR_OVERFLOW  = 3'd6
  } err_code_e;

  function automatic instr_fmt_e fmt_of(input logic [6:0] opcode, input logic [2:0] funct3);
    instr_fmt_e f;
    case (opcode)
      OP_R:             f = FMT_R;
      OP_I:             f = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
      OP_LOAD, OP_JALR: f = FMT_I;
      OP_S:             f = FMT_S;
      OP_B:             f = FMT_B;
      OP_LUI, OP_AUIPC: f = FMT_U;
      OP_JAL:           f = FMT_J;
      default:          f = FMT_BAD;
    endcase
    return f;
  endfunction

  // True when v[31:lsb] is a pure sign extension (all zeros or all ones).
  function automatic logic fits_signed(input logic [31:0] v, input int lsb);
    logic [31:0] s;
    s = 32'($signed(v) >>> lsb);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate legality checks; usable
// standalone as a reference assembler.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  instr_fmt_e  fmt,
  output logic [31:0] word,
  output err_code_e   err
);

  always_comb begin
    word = '0;
    err  = ERR_NONE;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        if (!fits_signed(imm, 11)) err = ERR_IMM_RANGE;
      end
      FMT_SH: begin
        word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        if (imm[31:5] != '0) err = ERR_SHAMT;
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!fits_signed(imm, 11)) err = ERR_IMM_RANGE;
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (!fits_signed(imm, 12)) err = ERR_IMM_RANGE;
        else if (imm[0])           err = ERR_MISALIGN;
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        if (imm[11:0] != '0) err = ERR_U_LOW;
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (!fits_signed(imm, 20)) err = ERR_IMM_RANGE;
        else if (imm[0])           err = ERR_MISALIGN;
      end
      default: err = ERR_OPCODE;
    endcase
  end

endmodule

// File: rtl/instruction_encode.sv
// Streaming RV32I encoder: accepts decoded field bundles and writes packed
// words sequentially into instruction memory from a programmable base.
module instruction_encode
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              err,
  output logic [2:0]        err_code
);

  // Handshakes: a bundle transfers on in_valid && in_ready; a memory write
  // transfers on mem_we && mem_ready, with mem_we/addr/wdata held until then.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state;
  logic [ADDR_W-1:0] wr_addr;
  instr_fmt_e        fmt;
  logic [31:0]       pack_word;
  err_code_e         pack_err;
  logic              at_limit;
  logic              accept;
  logic              overflow;

  assign fmt = fmt_of(opcode, funct3);

  instr_pack u_pack (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .imm    (imm),
    .fmt    (fmt),
    .word   (pack_word),
    .err    (pack_err)
  );

  // The pending word counts against DEPTH so we never accept one too many.
  assign at_limit = (count + CNT_W'(mem_we)) == CNT_W'(DEPTH);
  assign in_ready = (state == RUN) && (!mem_we || mem_ready) && !at_limit;
  assign accept   = in_valid && in_ready;
  assign overflow = (state == RUN) && in_valid && (count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_addr   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      if (mem_we && mem_ready) begin
        mem_we <= 1'b0;
        count  <= count + CNT_W'(1);
      end
      // Acceptance may refill the register in the same cycle it drains.
      if (accept && pack_err == ERR_NONE) begin
        mem_we    <= 1'b1;
        mem_addr  <= wr_addr;
        mem_wdata <= pack_word;
        wr_addr   <= wr_addr + ADDR_W'(4);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            wr_addr  <= base_addr & ~ADDR_W'(3);
            count    <= '0;
            err      <= 1'b0;
            err_code <= '0;
          end
        end
        RUN: begin
          if (accept && pack_err != ERR_NONE) begin
            state <= DRAIN;
            if (!err) begin
              err      <= 1'b1;
              err_code <= pack_err;
            end
          end else if (overflow) begin
            state <= DRAIN;
            if (!err) begin
              err      <= 1'b1;
              err_code <= ERR_OVERFLOW;
            end
          end else if (stop) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!mem_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encode.sv
// Bench for instruction_encode: vector table of known RV32I encodings, a write
// scoreboard, error/overflow/wrap/reset sequences.
module tb_instruction_encode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, stop, in_valid, in_ready, mem_we, mem_ready, busy, err;
  logic [15:0] base_addr, mem_addr, count;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3, err_code;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, mem_wdata;

  logic        s_start, s_stop, s_in_valid, s_in_ready, s_mem_we, s_mem_ready, s_busy, s_err;
  logic [15:0] s_base_addr, s_mem_addr, s_count;
  logic [2:0]  s_err_code;
  logic [31:0] s_mem_wdata;

  always #5 clk = ~clk;

  instruction_encode #(.ADDR_W(16), .DEPTH(1024), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .busy(busy), .err(err), .err_code(err_code)
  );

  instruction_encode #(.ADDR_W(16), .DEPTH(4), .CNT_W(16)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .base_addr(s_base_addr), .stop(s_stop),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .opcode(7'h13), .funct3(3'd0),
    .funct7(7'd0), .rd(5'd1), .rs1(5'd0), .rs2(5'd0), .imm(32'd1), .mem_we(s_mem_we),
    .mem_ready(s_mem_ready), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .count(s_count), .busy(s_busy), .err(s_err), .err_code(s_err_code)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [2:0]  code;
  } err_vec_t;

  vec_t        vecs[16];
  err_vec_t    evecs[8];
  logic [47:0] exp_q[$];
  logic [15:0] exp_addr;
  int          checks = 0;
  int          errors = 0;
  bit          acc;
  int          used;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and write-port protocol monitor.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_we", 32'(mem_we), 32'd1);
        chk("stall_addr", 32'(mem_addr), 32'(prev_addr));
        chk("stall_data", mem_wdata, prev_data);
      end
      if (mem_we && !mem_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty queue", mem_addr, mem_wdata);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e[47:32]));
          chk("wr_data", mem_wdata, e[31:0]);
        end
      end
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
    end
  end

  task automatic send(input vec_t v, input bit expect_write, input int budget,
                      output bit accepted, output int cycles);
    accepted = 1'b0;
    cycles   = 0;
    opcode = v.op; funct3 = v.f3; funct7 = v.f7;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    in_valid = 1'b1;
    while (!accepted && cycles < budget) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        if (expect_write) begin
          exp_q.push_back({exp_addr, v.word});
          exp_addr = exp_addr + 16'd4;
        end
      end
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] base);
    base_addr = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = base & 16'hFFFC;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_drop", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{7'h13, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'd5,        32'h00500093}; // addi x1,x0,5
    vecs[1]  = '{7'h33, 3'd0, 7'h00, 5'd3,  5'd1, 5'd2, 32'd0,        32'h002081B3}; // add x3,x1,x2
    vecs[2]  = '{7'h23, 3'd2, 7'h00, 5'd0,  5'd1, 5'd2, 32'd8,        32'h0020A423}; // sw x2,8(x1)
    vecs[3]  = '{7'h63, 3'd0, 7'h00, 5'd0,  5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3}; // beq -4
    vecs[4]  = '{7'h6F, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'd8,        32'h008000EF}; // jal x1,8
    vecs[5]  = '{7'h37, 3'd0, 7'h00, 5'd5,  5'd0, 5'd0, 32'h12345000, 32'h123452B7}; // lui
    vecs[6]  = '{7'h13, 3'd5, 7'h20, 5'd1,  5'd1, 5'd0, 32'd3,        32'h4030D093}; // srai
    vecs[7]  = '{7'h13, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'hFFFFF800, 32'h80000093}; // addi -2048
    vecs[8]  = '{7'h13, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'd2047,     32'h7FF00093}; // addi 2047
    vecs[9]  = '{7'h13, 3'd5, 7'h00, 5'd2,  5'd3, 5'd0, 32'd31,       32'h01F1D113}; // srli 31
    vecs[10] = '{7'h03, 3'd2, 7'h00, 5'd5,  5'd6, 5'd0, 32'hFFFFFFFF, 32'hFFF32283}; // lw -1
    vecs[11] = '{7'h17, 3'd0, 7'h00, 5'd10, 5'd0, 5'd0, 32'hFFFFF000, 32'hFFFFF517}; // auipc
    vecs[12] = '{7'h67, 3'd0, 7'h00, 5'd0,  5'd1, 5'd0, 32'd0,        32'h00008067}; // jalr
    vecs[13] = '{7'h6F, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0, 32'hFFFFF800, 32'h801FF06F}; // jal -2048
    vecs[14] = '{7'h63, 3'd1, 7'h00, 5'd0,  5'd3, 5'd4, 32'd4094,     32'h7E419FE3}; // bne +4094
    vecs[15] = '{7'h33, 3'd0, 7'h20, 5'd1,  5'd2, 5'd3, 32'd0,        32'h403100B3}; // sub

    evecs[0] = '{7'h7F, 3'd0, 32'd0,        3'd1}; // unknown opcode
    evecs[1] = '{7'h13, 3'd0, 32'h00001000, 3'd2}; // I imm too large
    evecs[2] = '{7'h23, 3'd2, 32'hFFFFF7FF, 3'd2}; // S imm -2049
    evecs[3] = '{7'h63, 3'd0, 32'h00002000, 3'd2}; // B imm too large
    evecs[4] = '{7'h6F, 3'd0, 32'h00100000, 3'd2}; // J imm too large
    evecs[5] = '{7'h6F, 3'd0, 32'd5,        3'd3}; // J odd
    evecs[6] = '{7'h37, 3'd0, 32'h12345001, 3'd4}; // U low bits
    evecs[7] = '{7'h13, 3'd1, 32'd32,       3'd5}; // slli shamt 32

    start = 0; stop = 0; in_valid = 0; base_addr = '0; mem_ready = 1'b1;
    opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    s_start = 0; s_stop = 0; s_in_valid = 0; s_base_addr = '0; s_mem_ready = 1'b1;
    exp_addr = '0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    chk("reset_small_busy", 32'(s_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First session: two words from 0x0100.
    pulse_start(16'h0100);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      send(vecs[i], 1'b1, 10, acc, used);
      chk("accept", 32'(acc), 32'd1);
    end
    wait_drain(20);
    chk("count_after_2", 32'(count), 32'd2);

    // Remaining table with a 5-cycle memory stall in the middle.
    fork
      begin
        for (int i = 2; i < 16; i++) begin
          send(vecs[i], 1'b1, 50, acc, used);
          chk("accept_stream", 32'(acc), 32'd1);
        end
      end
      begin
        repeat (3) @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (5) @(posedge clk); #1;
        mem_ready = 1'b1;
      end
    join
    wait_drain(40);
    chk("count_after_16", 32'(count), 32'd16);

    // Sustained rate after the stall: four bundles in four cycles.
    begin
      int total = 0;
      for (int i = 0; i < 4; i++) begin
        send(vecs[i], 1'b1, 10, acc, used);
        total += used;
      end
      chk("burst_cycles", 32'(total), 32'd4);
    end
    wait_drain(20);
    chk("count_after_20", 32'(count), 32'd20);
    pulse_stop();
    wait_idle(10);
    chk("stop_err", 32'(err), 32'd0);
    chk("stop_count", 32'(count), 32'd20);

    // Misaligned branch, then a bundle that must not be accepted.
    pulse_start(16'h0200);
    begin
      vec_t v;
      v = '{7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3, 32'd0};
      send(v, 1'b0, 10, acc, used);
      chk("beq_odd_accept", 32'(acc), 32'd1);
      @(negedge clk);
      chk("beq_odd_err", 32'(err), 32'd1);
      chk("beq_odd_code", 32'(err_code), 32'd3);
      @(posedge clk); #1;
      v = '{7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4096, 32'd0};
      send(v, 1'b0, 4, acc, used);
      chk("held_off", 32'(acc), 32'd0);
      chk("code_sticky", 32'(err_code), 32'd3);
    end
    wait_idle(10);
    chk("err_no_write", 32'(count), 32'd0);
    pulse_start(16'h0200);
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_code", 32'(err_code), 32'd0);
    pulse_stop();
    wait_idle(10);

    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = '{evecs[i].op, evecs[i].f3, 7'h00, 5'd1, 5'd2, 5'd3, evecs[i].imm, 32'd0};
      pulse_start(16'h0300);
      send(v, 1'b0, 10, acc, used);
      chk("err_accept", 32'(acc), 32'd1);
      @(negedge clk);
      chk("err_code_tbl", 32'(err_code), 32'(evecs[i].code));
      @(posedge clk); #1;
      wait_idle(10);
      chk("err_tbl_count", 32'(count), 32'd0);
    end

    // Base low bits ignored and address wraps past 0xFFFC.
    pulse_start(16'hFFFB);
    for (int i = 0; i < 3; i++) begin
      send(vecs[i], 1'b1, 10, acc, used);
      chk("wrap_accept", 32'(acc), 32'd1);
    end
    wait_drain(20);
    chk("wrap_last_addr", 32'(mem_addr), 32'h0000);
    chk("wrap_err", 32'(err), 32'd0);
    pulse_stop();
    wait_idle(10);

    // DEPTH=4 instance: six bundles offered, four written, overflow flagged.
    begin
      int s_acc = 0;
      int s_wr = 0;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      s_in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (s_in_valid && s_in_ready) s_acc++;
        if (s_mem_we && s_mem_ready) s_wr++;
        if (s_acc == 6) s_in_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_in_valid = 1'b0;
      chk("ovf_accepts", 32'(s_acc), 32'd4);
      chk("ovf_writes", 32'(s_wr), 32'd4);
      chk("ovf_count", 32'(s_count), 32'd4);
      chk("ovf_err", 32'(s_err), 32'd1);
      chk("ovf_code", 32'(s_err_code), 32'd6);
      chk("ovf_busy", 32'(s_busy), 32'd0);
    end

    // Reset while a write is pending drops it.
    pulse_start(16'h0400);
    mem_ready = 1'b0;
    send(vecs[0], 1'b1, 10, acc, used);
    chk("rst_mid_accept", 32'(acc), 32'd1);
    @(negedge clk);
    chk("rst_mid_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
